forwarding_scoreboard_id: RTL and testbench
===========================================

// Module: forwarding_scoreboard_id
// PURPOSE
//  ID-stage operand-forwarding and load-use hazard unit, generalised to NUM_SRC source ports and DEPTH in-flight stages.
//  Keeps an internal shadow pipeline of in-flight register writes (slot 0 = EX, slot DEPTH-1 = WB).
//  From it, produces a per-source forward select (youngest producer wins) and an ID stall when that producer's result is not yet ready.
//  Also counts stall cycles for performance monitoring.
// PARAMETERS
//  NUM_SRC     2   number of ID source-register ports (rs, rt, ...)
//  REG_ADDR_W  5   register address width
//  DEPTH       3   in-flight stages tracked after ID (EX, MEM, WB)
//  CNT_W       16  stall counter width
//  SEL_W = $clog2(DEPTH+1), RDY_W = $clog2(DEPTH)  (localparams)
// PORTS
//  clk           in   1                   clock, rising edge
//  rst_n         in   1                   asynchronous reset, active low
//  pipe_en       in   1                   global pipeline advance; 0 freezes all state
//  id_valid      in   1                   ID holds a valid instruction
//  flush_id      in   1                   kill the ID instruction this cycle
//  id_src        in   NUM_SRC*REG_ADDR_W  source register addresses, port i at [i*REG_ADDR_W +: REG_ADDR_W]
//  id_src_used   in   NUM_SRC             port i is actually read
//  id_rd         in   REG_ADDR_W          destination register
//  id_reg_write  in   1                   instruction writes id_rd
//  id_ready_at   in   RDY_W               first slot index whose value is forwardable (ALU=0, load=1)
//  fwd_sel       out  NUM_SRC*SEL_W       per port: 0 = register file, k+1 = forward from slot k
//  stall         out  1                   hold IF/ID, insert bubble into EX
//  stall_count   out  CNT_W               saturating count of stall cycles
// BEHAVIOUR
//  - Slot contents: valid, rd, ready_at. Reset clears every slot valid bit and stall_count.
//    stall=0 and fwd_sel=0 follow immediately, asynchronously.
//  - Match for port i at slot k:
//    slot[k].valid && slot[k].rd==id_src[i] && id_src_used[i] && id_src[i]!=0.
//    Register 0 never matches.
//  - Priority: the lowest matching k (youngest producer) wins. Older matches are ignored.
//  - Hazard: the winning k < slot[k].ready_at on any port.
//    stall = id_valid && !flush_id && hazard. stall is combinational (0-cycle latency).
//  - fwd_sel[i] = k+1 for the winning slot, else 0. All fwd_sel are forced to 0 while stall=1.
//  - Edge with pipe_en=1:
//    - slot[k+1] <= slot[k] for k = 0..DEPTH-2; slot[DEPTH-1] contents retire.
//    - The register file is write-first, so a retired value is read directly.
//    - slot0 <= {id_reg_write && id_rd!=0, id_rd, id_ready_at} when id_valid && !stall && !flush_id.
//      Otherwise slot0 <= bubble (valid=0).
//  - Edge with pipe_en=0: all slots and stall_count hold. stall/fwd_sel stay valid combinationally.
//  - stall_count: +1 on each edge with pipe_en && stall; saturates at all-ones (no wrap).
//  - Load-use with ready_at=1: exactly one stall cycle, then fwd_sel=2 (MEM).
//  - Larger ready_at gives proportionally more stall cycles.
//  - flush_id and stall together: flush wins; stall=0 and a bubble is inserted.
//  - id_ready_at >= DEPTH is illegal; the bench asserts it never occurs.
//  - Reset asserted mid-stall: the stall drops at once. No partial state survives.
// STRUCTURE
//  - Shared package mips_pipe_pkg:
//    - REG_ADDR_W
//    - fwd_slot_t struct {valid, rd, ready_at}
//    - FWD_SEL_RF = 0 constant
//  - Sub-module fwd_match_port: one per source port via generate.
//    - Priority encoder over DEPTH slots.
//    - Outputs sel and the per-port hazard bit.
//  - Top level contains the slot shift register, the OR of per-port hazards and the counter.
// TESTING
//  1 ALU back-to-back: issue rd=5 ready_at=0; next cycle src0=5 -> fwd_sel[0]=1, stall=0.
//  2 Load-use: issue rd=8 ready_at=1; next cycle src1=8 -> stall=1, fwd_sel=0.
//    Following cycle -> stall=0, fwd_sel[1]=2, stall_count=1.
//  3 Youngest wins: rd=3 issued on two consecutive cycles; then src0=3 -> fwd_sel[0]=1, not 2.
//    After 3 idle cycles -> fwd_sel[0]=0.
//  4 r0 and unused ports: rd=0 reg_write=1, then src0=0 -> sel 0.
//    src1=matching rd with id_src_used[1]=0 -> sel 0, no stall.
//  5 Freeze and flush: in case 2, hold pipe_en=0 for 3 cycles -> stall stays 1, stall_count stays 0.
//    Then flush_id=1 -> stall=0 and a bubble enters slot 0.
//  6 Async reset mid-stall, and counter saturation:
//    - rst_n low between edges -> stall=0, fwd_sel=0, stall_count=0 before the next edge.
//    - With CNT_W=2, 5 stall cycles -> stall_count=3.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions for the ID-stage forwarding scoreboard.
// Holds the default register address width, the in-flight slot layout
// for the default three-stage configuration, and the "read register file"
// forward select code.
package mips_pipe_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int PIPE_DEPTH = 3;
  localparam int PIPE_RDY_W = $clog2(PIPE_DEPTH);

  localparam int FWD_SEL_RF = 0;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [PIPE_RDY_W-1:0] readyAt;
  } fwd_slot_t;

endpackage

// File: rtl/fwd_match_port.sv
// Per-source-port priority encoder over the in-flight slots.
// Finds the youngest slot writing this port's source register and reports
// whether that producer's value is still not forwardable.
module fwd_match_port
  import mips_pipe_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 3,
  parameter int SEL_W  = 2,
  parameter int RDY_W  = 2
) (
  input  logic [DEPTH-1:0]        slotValid_i,
  input  logic [DEPTH*ADDR_W-1:0] slotRd_i,
  input  logic [DEPTH*RDY_W-1:0]  slotReadyAt_i,
  input  logic [ADDR_W-1:0]       src_i,
  input  logic                    srcUsed_i,
  output logic [SEL_W-1:0]        sel_o,
  output logic                    hazard_o
);

  // Scan oldest to youngest so the youngest matching producer overwrites older ones
  always_comb begin
    sel_o    = SEL_W'(FWD_SEL_RF);
    hazard_o = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (slotValid_i[k] && (slotRd_i[k*ADDR_W +: ADDR_W] == src_i) &&
          srcUsed_i && (src_i != '0)) begin
        sel_o    = SEL_W'(k + 1);
        hazard_o = (RDY_W'(k) < slotReadyAt_i[k*RDY_W +: RDY_W]);
      end
    end
  end

endmodule

// File: rtl/forwarding_scoreboard_id.sv
// ID-stage forwarding and load-use hazard unit.
// Shadows the in-flight register writes (slot 0 = EX, last slot = WB),
// picks a forward source per ID operand, stalls ID when the chosen producer
// is not ready yet, and keeps a saturating count of stall cycles.
module forwarding_scoreboard_id #(
  parameter  int NUM_SRC    = 2,
  parameter  int REG_ADDR_W = mips_pipe_pkg::REG_ADDR_W,
  parameter  int DEPTH      = 3,
  parameter  int CNT_W      = 16,
  localparam int SEL_W      = $clog2(DEPTH + 1),
  localparam int RDY_W      = $clog2(DEPTH)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          pipe_en_i,
  input  logic                          id_valid_i,
  input  logic                          flush_id_i,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_i,
  input  logic [NUM_SRC-1:0]            id_src_used_i,
  input  logic [REG_ADDR_W-1:0]         id_rd_i,
  input  logic                          id_reg_write_i,
  input  logic [RDY_W-1:0]              id_ready_at_i,
  output logic [NUM_SRC*SEL_W-1:0]      fwd_sel_o,
  output logic                          stall_o,
  output logic [CNT_W-1:0]              stall_count_o
);

  import mips_pipe_pkg::*;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [RDY_W-1:0]      readyAt;
  } slot_t;

  slot_t                     slot_q [DEPTH];
  slot_t                     slot0_d;
  logic [CNT_W-1:0]          stallCount_q;
  logic [CNT_W-1:0]          stallCount_d;

  logic [DEPTH-1:0]          slotValid;
  logic [DEPTH*REG_ADDR_W-1:0] slotRd;
  logic [DEPTH*RDY_W-1:0]    slotReadyAt;
  logic [NUM_SRC*SEL_W-1:0]  portSel;
  logic [NUM_SRC-1:0]        portHazard;
  logic                      stall;

  for (genvar k = 0; k < DEPTH; k++) begin : gSlot
    assign slotValid[k]                          = slot_q[k].valid;
    assign slotRd[k*REG_ADDR_W +: REG_ADDR_W]    = slot_q[k].rd;
    assign slotReadyAt[k*RDY_W +: RDY_W]         = slot_q[k].readyAt;
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : gPort
    fwd_match_port #(
      .ADDR_W(REG_ADDR_W),
      .DEPTH (DEPTH),
      .SEL_W (SEL_W),
      .RDY_W (RDY_W)
    ) uMatch (
      .slotValid_i  (slotValid),
      .slotRd_i     (slotRd),
      .slotReadyAt_i(slotReadyAt),
      .src_i        (id_src_i[i*REG_ADDR_W +: REG_ADDR_W]),
      .srcUsed_i    (id_src_used_i[i]),
      .sel_o        (portSel[i*SEL_W +: SEL_W]),
      .hazard_o     (portHazard[i])
    );
  end

  assign stall         = id_valid_i && !flush_id_i && (|portHazard);
  assign stall_o       = stall;
  assign fwd_sel_o     = stall ? {NUM_SRC{SEL_W'(FWD_SEL_RF)}} : portSel;
  assign stall_count_o = stallCount_q;

  // New EX-slot entry (a bubble unless ID issues) and the saturating stall counter
  always_comb begin
    slot0_d = '0;
    if (id_valid_i && !stall && !flush_id_i) begin
      slot0_d.valid   = id_reg_write_i && (id_rd_i != '0);
      slot0_d.rd      = id_rd_i;
      slot0_d.readyAt = id_ready_at_i;
    end
    stallCount_d = stallCount_q;
    if (stall && (stallCount_q != '1)) begin
      stallCount_d = stallCount_q + 1'b1;
    end
  end

  // Advance the shadow pipeline and counter only when the whole pipe advances
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < DEPTH; k++) begin
        slot_q[k] <= '0;
      end
      stallCount_q <= '0;
    end else if (pipe_en_i) begin
      slot_q[0] <= slot0_d;
      for (int k = 1; k < DEPTH; k++) begin
        slot_q[k] <= slot_q[k-1];
      end
      stallCount_q <= stallCount_d;
    end
  end

endmodule

// File: tb/tb_forwarding_scoreboard_id.sv
// Bench for forwarding_scoreboard_id: directed vector table, hand-written
// reset and saturation sequences, then random traffic against a model.
module tb_forwarding_scoreboard_id;

  localparam int NUM_SRC = 2;
  localparam int AW      = 5;
  localparam int DEPTH   = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_en;
  logic        id_valid;
  logic        flush_id;
  logic [9:0]  id_src;
  logic [1:0]  id_src_used;
  logic [4:0]  id_rd;
  logic        id_reg_write;
  logic [1:0]  id_ready_at;
  logic [3:0]  fwd_sel;
  logic        stall;
  logic [15:0] stall_count;
  logic [3:0]  fwdSelSat;
  logic        stallSat;
  logic [1:0]  satCount;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  forwarding_scoreboard_id #(.NUM_SRC(2), .REG_ADDR_W(5), .DEPTH(3), .CNT_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .pipe_en_i(pipe_en), .id_valid_i(id_valid),
    .flush_id_i(flush_id), .id_src_i(id_src), .id_src_used_i(id_src_used),
    .id_rd_i(id_rd), .id_reg_write_i(id_reg_write), .id_ready_at_i(id_ready_at),
    .fwd_sel_o(fwd_sel), .stall_o(stall), .stall_count_o(stall_count)
  );

  forwarding_scoreboard_id #(.NUM_SRC(2), .REG_ADDR_W(5), .DEPTH(3), .CNT_W(2)) dutSat (
    .clk_i(clk), .rst_ni(rst_n), .pipe_en_i(pipe_en), .id_valid_i(id_valid),
    .flush_id_i(flush_id), .id_src_i(id_src), .id_src_used_i(id_src_used),
    .id_rd_i(id_rd), .id_reg_write_i(id_reg_write), .id_ready_at_i(id_ready_at),
    .fwd_sel_o(fwdSelSat), .stall_o(stallSat), .stall_count_o(satCount)
  );

  always @(posedge clk) begin
    if (rst_n) assert (id_ready_at < DEPTH) else $error("[TB] illegal id_ready_at %0d", id_ready_at);
  end

  typedef struct {
    int en, v, fl, s0, s1, used, rd, we, ra;
    int st, e0, e1, cnt;
  } vec_t;

  vec_t tbl[22];

  // Model: list of in-flight writers, index 0 = youngest (EX), by age
  bit mValid[DEPTH];
  int mRd[DEPTH];
  int mRdy[DEPTH];
  int mCount;
  bit expStall;
  int expSel[NUM_SRC];

  function automatic vec_t mk(int en, int v, int fl, int s0, int s1, int used, int rd,
                              int we, int ra, int st, int e0, int e1, int cnt);
    vec_t r;
    r.en = en; r.v = v; r.fl = fl; r.s0 = s0; r.s1 = s1; r.used = used;
    r.rd = rd; r.we = we; r.ra = ra; r.st = st; r.e0 = e0; r.e1 = e1; r.cnt = cnt;
    return r;
  endfunction

  task automatic resetModel();
    for (int k = 0; k < DEPTH; k++) begin
      mValid[k] = 0; mRd[k] = 0; mRdy[k] = 0;
    end
    mCount = 0;
  endtask

  task automatic modelEval();
    bit haz;
    bit found;
    int src;
    haz = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src = int'(id_src[i*AW +: AW]);
      expSel[i] = 0;
      found = 0;
      if (id_src_used[i] && src != 0) begin
        for (int age = 0; age < DEPTH; age++) begin
          if (!found && mValid[age] && mRd[age] == src) begin
            found = 1;
            expSel[i] = age + 1;
            if (age < mRdy[age]) haz = 1;
          end
        end
      end
    end
    expStall = id_valid && !flush_id && haz;
    if (expStall) begin
      for (int i = 0; i < NUM_SRC; i++) expSel[i] = 0;
    end
  endtask

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkOutput(string name, int st, int e0, int e1, int cnt);
    check({name, "_stall"}, int'(stall), st);
    check({name, "_sel0"}, int'(fwd_sel[1:0]), e0);
    check({name, "_sel1"}, int'(fwd_sel[3:2]), e1);
    check({name, "_count"}, int'(stall_count), cnt);
    check({name, "_satcount"}, int'(satCount), (cnt > 3) ? 3 : cnt);
  endtask

  task automatic checkModel(string name);
    modelEval();
    checkOutput(name, int'(expStall), expSel[0], expSel[1], mCount);
  endtask

  task automatic applyStimulus(vec_t s);
    pipe_en      = s.en[0];
    id_valid     = s.v[0];
    flush_id     = s.fl[0];
    id_src       = {5'(s.s1), 5'(s.s0)};
    id_src_used  = 2'(s.used);
    id_rd        = 5'(s.rd);
    id_reg_write = s.we[0];
    id_ready_at  = 2'(s.ra);
    #1;
  endtask

  // Advance the model to match the coming clock edge, then step to the next falling edge
  task automatic clockEdge();
    modelEval();
    if (pipe_en) begin
      for (int age = DEPTH - 1; age > 0; age--) begin
        mValid[age] = mValid[age-1]; mRd[age] = mRd[age-1]; mRdy[age] = mRdy[age-1];
      end
      if (id_valid && !expStall && !flush_id) begin
        mValid[0] = id_reg_write && (id_rd != 0);
        mRd[0]    = int'(id_rd);
        mRdy[0]   = int'(id_ready_at);
      end else begin
        mValid[0] = 0;
      end
      if (expStall && mCount < 65535) mCount++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vec_t rv;
    //               en v fl s0 s1 used rd we ra   st e0 e1 cnt
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 0, 0, 0, 0, 5, 1, 0,  0, 0, 0, 0);
    tbl[2]  = mk(1, 1, 0, 5, 0, 1, 0, 0, 0,  0, 1, 0, 0);
    tbl[3]  = mk(1, 1, 0, 0, 0, 0, 8, 1, 1,  0, 0, 0, 0);
    tbl[4]  = mk(1, 1, 0, 0, 8, 2, 0, 0, 0,  1, 0, 0, 0);
    tbl[5]  = mk(1, 1, 0, 0, 8, 2, 0, 0, 0,  0, 0, 2, 1);
    tbl[6]  = mk(1, 1, 0, 0, 0, 0, 3, 1, 0,  0, 0, 0, 1);
    tbl[7]  = mk(1, 1, 0, 0, 0, 0, 3, 1, 0,  0, 0, 0, 1);
    tbl[8]  = mk(1, 1, 0, 3, 0, 1, 0, 0, 0,  0, 1, 0, 1);
    tbl[9]  = mk(1, 0, 0, 3, 0, 1, 0, 0, 0,  0, 2, 0, 1);
    tbl[10] = mk(1, 0, 0, 3, 0, 1, 0, 0, 0,  0, 3, 0, 1);
    tbl[11] = mk(1, 0, 0, 3, 0, 1, 0, 0, 0,  0, 0, 0, 1);
    tbl[12] = mk(1, 1, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 1);
    tbl[13] = mk(1, 1, 0, 0, 0, 1, 9, 1, 0,  0, 0, 0, 1);
    tbl[14] = mk(1, 1, 0, 0, 9, 1, 0, 0, 0,  0, 0, 0, 1);
    tbl[15] = mk(1, 1, 0, 0, 9, 2, 0, 0, 0,  0, 0, 2, 1);
    tbl[16] = mk(1, 1, 0, 0, 0, 0, 8, 1, 1,  0, 0, 0, 1);
    tbl[17] = mk(0, 1, 0, 0, 8, 2, 0, 0, 0,  1, 0, 0, 1);
    tbl[18] = mk(0, 1, 0, 0, 8, 2, 0, 0, 0,  1, 0, 0, 1);
    tbl[19] = mk(0, 1, 0, 0, 8, 2, 0, 0, 0,  1, 0, 0, 1);
    tbl[20] = mk(1, 1, 1, 0, 8, 2, 12, 1, 0, 0, 0, 1, 1);
    tbl[21] = mk(1, 1, 0, 12, 8, 3, 0, 0, 0, 0, 0, 2, 1);

    rst_n = 1'b0;
    applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    resetModel();
    @(negedge clk);
    checkOutput("reset", 0, 0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      applyStimulus(tbl[i]);
      checkOutput($sformatf("vec%0d", i), tbl[i].st, tbl[i].e0, tbl[i].e1, tbl[i].cnt);
      clockEdge();
    end

    // Asynchronous reset in the middle of a load-use stall
    applyStimulus(mk(1, 1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0, 0));
    checkModel("rst_load");
    clockEdge();
    applyStimulus(mk(1, 1, 0, 6, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    check("rst_pre_stall", int'(stall), 1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_async", 0, 0, 0, 0);
    resetModel();
    rst_n = 1'b1;
    #1;
    checkModel("rst_release");
    clockEdge();

    // Three two-cycle load-use stalls: 6 stall cycles in total
    for (int n = 0; n < 3; n++) begin
      applyStimulus(mk(1, 1, 0, 0, 0, 0, 7, 1, 2, 0, 0, 0, 0));
      checkModel($sformatf("sat_load%0d", n));
      clockEdge();
      for (int c = 0; c < 3; c++) begin
        applyStimulus(mk(1, 1, 0, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        checkModel($sformatf("sat_use%0d_%0d", n, c));
        clockEdge();
      end
    end
    check("sat_main_count", int'(stall_count), 6);
    check("sat_narrow_count", int'(satCount), 3);

    for (int n = 0; n < 400; n++) begin
      rv = mk(($urandom % 8) != 0, ($urandom % 4) != 0, ($urandom % 10) == 0,
              $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3),
              $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 2),
              0, 0, 0, 0);
      applyStimulus(rv);
      checkModel($sformatf("rand%0d", n));
      clockEdge();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
